game_state_keeper: RTL
======================

# game_state_keeper

Holds the live puzzle state (walkable map, box map, player cursor) consumed by `game_controller` and the renderer, and keeps a bounded undo history for the retract feature. It sits directly downstream of `game_controller`: `game_state_en` and `sel` choose what is written each cycle. The choices are reload the stage map, commit a move, or pop the last move. The block also keeps a step counter for the score display.

## Interface
Parameters:
- `DEPTH`, 8: number of undo entries. Must be a power of two, 2..16.
- `PW`, 3: pointer width, equal to log2(DEPTH).

Ports:
- `clk`, in, 1: system clock. All state updates on its rising edge.
- `reset_n`, in, 1: reset, synchronous and active-low.
- `game_state_en`, in, 1: write enable from `game_controller`.
- `sel`, in, 2: source select. 0 = stage init, 1 = move, 3 = retract, 2 = reserved.
- `init_state`, in, 134: stage ROM image, laid out as {way[63:0], box[63:0], cursor[5:0]}.
- `move_state`, in, 134: next state computed by the move logic. Same layout as `init_state`.
- `game_state`, out, 134: current state, registered. way = [133:70], box = [69:6], player = [5:0].
- `step_count`, out, 10: number of moves taken in the current stage, registered.
- `can_retract`, out, 1: high when the history holds at least one entry. Registered.

## Operation
- All state lives in registers: `game_state`, `step_count`, a history array `hist[DEPTH]` of 134-bit entries, a write pointer `wp[PW-1:0]` and an occupancy count `cnt` (0..DEPTH).
- `can_retract` = (cnt != 0), registered alongside `cnt`.
- When `reset_n` = 0: `game_state` = 0, `step_count` = 0, `wp` = 0, `cnt` = 0, `can_retract` = 0. The contents of `hist` are don't-care.
- `game_state_en` = 0: everything holds.
- `game_state_en` = 1 with `sel` = 0 (INIT / RESET / retry):
  - `game_state` ← `init_state`.
  - `cnt` ← 0, `wp` ← 0, `step_count` ← 0.
  - Repeated cycles in this mode are legal and idempotent.
- `game_state_en` = 1 with `sel` = 1 (MOVE):
  - `hist[wp]` ← the old `game_state`.
  - `wp` ← wp+1, wrapping modulo DEPTH.
  - `cnt` ← min(cnt+1, DEPTH). When the history is full, the oldest entry is overwritten and `cnt` stays at DEPTH.
  - `game_state` ← `move_state`.
  - `step_count` ← step_count+1, saturating at 1023.
- `game_state_en` = 1 with `sel` = 3 (RETRACT):
  - If cnt > 0: `game_state` ← `hist[wp-1]` (index modulo DEPTH), `wp` ← wp-1, `cnt` ← cnt-1, and `step_count` ← step_count-1 if it is nonzero.
  - If cnt = 0: no change at all. An empty retract is a silent no-op.
- `game_state_en` = 1 with `sel` = 2: no change. This code is reserved.
- A retract is never rejected because of `step_count`. The history depth alone decides whether a retract takes effect.
- The history array is never read and written in the same cycle, because exactly one `sel` action applies per cycle.

## Timing
- Latency is one cycle. An action sampled at edge N is visible on `game_state`, `step_count` and `can_retract` immediately after edge N.
- `game_controller` asserts enable for exactly one cycle in its MOVE and RETRACT states. The effect is visible to its WAIT state at the next edge, in time for the win check.
- Reading `hist[wp-1]` is a combinational mux from the register array. No RAM read latency is allowed.
- Reset priority: `reset_n` = 0 overrides any enable or sel on that edge, including in the middle of a move or retract.
- After DEPTH+k moves, only the last DEPTH states can be recovered. The (DEPTH+1)-th consecutive retract is a no-op.

## Test plan
- Reset, then en=1 sel=0 with `init_state` = A for 2 cycles → `game_state` = A, `step_count` = 0, `can_retract` = 0.
- From A: a move to B (sel=1), then a move to C → `step_count` = 2, `can_retract` = 1. Retract → `game_state` = B, count 1. Retract → A, count 0, `can_retract` = 0. A third retract → still A, count 0.
- Wrap: from S0, make 10 moves S1..S10 with DEPTH=8. Then 8 retracts → states S9, S8, …, S2 in order. A 9th retract → holds S2, `can_retract` = 0, `step_count` = 2.
- Interleave: move, retract, move, move, retract → `game_state` equals the state after the first post-retract move, `step_count` = 1, `cnt` = 1.
- `reset_n` pulled low on the same edge as en=1 sel=1 → outputs are all 0 and the history is empty. The move is discarded.
- en=1 sel=2, and en=0 with sel=1 → no output change. Also drive 1030 moves and check `step_count` saturates at 1023.

Source files
------------

// File: rtl/game_state_keeper_if.sv
// game_state_keeper_if: controller-to-state-keeper bus (write request and live state)
interface game_state_keeper_if;
  logic         game_state_en;
  logic [1:0]   sel;
  logic [133:0] init_state;
  logic [133:0] move_state;
  logic [133:0] game_state;
  logic [9:0]   step_count;
  logic         can_retract;
  modport master (
    output game_state_en, sel, init_state, move_state,
    input  game_state, step_count, can_retract
  );
  modport slave (
    input  game_state_en, sel, init_state, move_state,
    output game_state, step_count, can_retract
  );
endinterface

// File: rtl/game_state_keeper.sv
// game_state_keeper: live puzzle state, step counter and bounded undo history
module game_state_keeper #(
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input logic                clk,
  input logic                reset_n,
  game_state_keeper_if.slave bus
);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [133:0]  hist [DEPTH];
  logic [133:0]  gs;
  logic [9:0]    step;
  logic          cr;
  logic [PW-1:0] wp;
  logic [PW-1:0] wp_prev;
  logic [PW:0]   cnt;
  logic          do_move;
  logic          do_retract;
  assign wp_prev    = wp - 1'b1;
  assign do_move    = bus.game_state_en && bus.sel == 2'd1;
  assign do_retract = bus.game_state_en && bus.sel == 2'd3 && cnt != '0;
  assign bus.game_state  = gs;
  assign bus.step_count  = step;
  assign bus.can_retract = cr;
  // push the pre-move state; contents need no reset since cnt gates reads
  always_ff @(posedge clk)
    if (reset_n && do_move) hist[wp] <= gs;
  // state, pointer, occupancy and step counter; one action per enabled cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gs   <= '0;
      step <= '0;
      wp   <= '0;
      cnt  <= '0;
      cr   <= 1'b0;
    end else if (bus.game_state_en && bus.sel == 2'd0) begin
      gs   <= bus.init_state;
      step <= '0;
      wp   <= '0;
      cnt  <= '0;
      cr   <= 1'b0;
    end else if (do_move) begin
      gs   <= bus.move_state;
      step <= step == 10'd1023 ? step : step + 10'd1;
      wp   <= wp + 1'b1;
      cnt  <= cnt == FULL ? cnt : cnt + 1'b1;
      cr   <= 1'b1;
    end else if (do_retract) begin
      gs   <= hist[wp_prev];
      step <= step != '0 ? step - 10'd1 : step;
      wp   <= wp_prev;
      cnt  <= cnt - 1'b1;
      cr   <= cnt != (PW+1)'(1);
    end
  end
endmodule
